// File: rtl/axi3_pkg.sv
// axi3_pkg: shared burst/response encodings, FSM states, default widths and burst legality check
package axi3_pkg;
    localparam int AXI_ID_W      = 4;
    localparam int AXI_ADDR_W    = 32;
    localparam int AXI_DATA_W    = 32;
    localparam int AXI_MEM_BYTES = 4096;

    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    // A burst is unusable as a whole when its type, wrap length or beat size is illegal
    function automatic logic bad_burst(logic [1:0] burst, logic [3:0] len, logic [2:0] size, int nb);
        return burst == 2'b11 ||
               (burst == WRAP && !(len inside {4'd1, 4'd3, 4'd7, 4'd15})) ||
               (1 << size) > nb;
    endfunction
endpackage

// File: rtl/axi_if.sv
// axi_if: AXI3 channel bundle between a bus master and the slave endpoint
interface axi_if import axi3_pkg::*; #(
    parameter int ID_W   = AXI_ID_W,
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi3_addr_gen.sv
// axi3_addr_gen: address of the following beat for FIXED, INCR and WRAP bursts
module axi3_addr_gen import axi3_pkg::*; #(
    parameter int ADDR_W = AXI_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [3:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next
);
    logic [ADDR_W-1:0] step, wmask, incr;

    always_comb begin
        step  = ADDR_W'(1) << size;
        wmask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        incr  = (addr & ~(step - ADDR_W'(1))) + step;
        next  = burst == FIXED ? addr :
                burst == WRAP  ? (addr & ~wmask) | (incr & wmask) : incr;
    end
endmodule

// File: rtl/axi3_slave.sv
// axi3_slave: AXI3 slave over an internal word-organised memory,
// with independent single-outstanding write and read burst engines
module axi3_slave import axi3_pkg::*; #(
    parameter int ADDR_W    = AXI_ADDR_W,
    parameter int DATA_W    = AXI_DATA_W,
    parameter int MEM_BYTES = AXI_MEM_BYTES
) (
    input logic  aclk,
    input logic  aresetn,
    axi_if.slave axi
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int MB = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] TOP = ADDR_W'(MEM_BYTES);

    logic [DATA_W-1:0] mem [MEM_BYTES/NB];

    wstate_e           wstate, wnext;
    logic [ADDR_W-1:0] waddr, waddr_nx;
    logic [3:0]        wlen, wcnt;
    logic [2:0]        wsize;
    logic [1:0]        wburst;
    logic              werr, aw_hs, w_hs, w_bad, w_end, w_fault;

    rstate_e           rstate, rnext;
    logic [ADDR_W-1:0] raddr, raddr_nx, rd_addr;
    logic [3:0]        rlen, rcnt;
    logic [2:0]        rsize;
    logic [1:0]        rburst;
    logic              ar_hs, r_hs, rd_bad, r_load;

    logic unused;
    assign unused = ^{axi.awlock, axi.awcache, axi.awprot, axi.arlock, axi.arcache, axi.arprot, axi.wid};

    axi3_addr_gen #(.ADDR_W(ADDR_W)) u_wgen (
        .addr(waddr), .size(wsize), .len(wlen), .burst(wburst), .next(waddr_nx)
    );
    axi3_addr_gen #(.ADDR_W(ADDR_W)) u_rgen (
        .addr(raddr), .size(rsize), .len(rlen), .burst(rburst), .next(raddr_nx)
    );

    always_comb begin
        aw_hs   = axi.awvalid && axi.awready;
        w_hs    = axi.wvalid && axi.wready;
        w_end   = wcnt == wlen;
        w_bad   = bad_burst(wburst, wlen, wsize, NB) || waddr >= TOP;
        w_fault = werr || w_bad || (axi.wlast != w_end);
        wnext   = wstate == W_IDLE ? (aw_hs ? W_DATA : W_IDLE) :
                  wstate == W_DATA ? (w_hs && w_end ? W_RESP : W_DATA) :
                  (axi.bready ? W_IDLE : W_RESP);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate      <= W_IDLE;
            axi.awready <= 1'b0;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bid     <= '0;
            axi.bresp   <= OKAY;
            waddr       <= '0;
            wlen        <= '0;
            wsize       <= '0;
            wburst      <= '0;
            wcnt        <= '0;
            werr        <= 1'b0;
        end else begin
            wstate      <= wnext;
            axi.awready <= wnext == W_IDLE;
            axi.wready  <= wnext == W_DATA;
            axi.bvalid  <= wnext == W_RESP;
            if (aw_hs) begin
                axi.bid <= axi.awid;
                waddr   <= axi.awaddr;
                wlen    <= axi.awlen;
                wsize   <= axi.awsize;
                wburst  <= axi.awburst;
                wcnt    <= '0;
                werr    <= 1'b0;
            end
            if (w_hs) begin
                waddr <= waddr_nx;
                wcnt  <= wcnt + 4'd1;
                werr  <= w_fault;
                if (w_end)
                    axi.bresp <= w_fault ? SLVERR : OKAY;
            end
        end
    end

    // Memory is deliberately outside the reset domain so contents survive reset
    always_ff @(posedge aclk)
        for (int i = 0; i < NB; i++)
            if (w_hs && !w_bad && axi.wstrb[i])
                mem[waddr[MB-1:LB]][8*i +: 8] <= axi.wdata[8*i +: 8];

    always_comb begin
        ar_hs   = axi.arvalid && axi.arready;
        r_hs    = axi.rvalid && axi.rready;
        r_load  = ar_hs || (r_hs && !axi.rlast);
        rd_addr = ar_hs ? axi.araddr : raddr_nx;
        rd_bad  = (ar_hs ? bad_burst(axi.arburst, axi.arlen, axi.arsize, NB)
                         : bad_burst(rburst, rlen, rsize, NB)) || rd_addr >= TOP;
        rnext   = rstate == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) :
                  (r_hs && axi.rlast ? R_IDLE : R_DATA);
    end

    // rdata/rresp/rlast are only reloaded on a handshake, so they hold while stalled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate      <= R_IDLE;
            axi.arready <= 1'b0;
            axi.rvalid  <= 1'b0;
            axi.rid     <= '0;
            axi.rdata   <= '0;
            axi.rresp   <= OKAY;
            axi.rlast   <= 1'b0;
            raddr       <= '0;
            rlen        <= '0;
            rsize       <= '0;
            rburst      <= '0;
            rcnt        <= '0;
        end else begin
            rstate      <= rnext;
            axi.arready <= rnext == R_IDLE;
            axi.rvalid  <= rnext == R_DATA;
            if (ar_hs) begin
                axi.rid <= axi.arid;
                raddr   <= axi.araddr;
                rlen    <= axi.arlen;
                rsize   <= axi.arsize;
                rburst  <= axi.arburst;
                rcnt    <= '0;
            end else if (r_hs) begin
                raddr <= raddr_nx;
                rcnt  <= rcnt + 4'd1;
            end
            if (r_load) begin
                axi.rdata <= rd_bad ? '0 : mem[rd_addr[MB-1:LB]];
                axi.rresp <= rd_bad ? SLVERR : OKAY;
                axi.rlast <= ar_hs ? axi.arlen == 4'd0 : rcnt + 4'd1 == rlen;
            end else if (r_hs)
                axi.rlast <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi3_slave.sv
// tb_axi3_slave: randomized scoreboard bench for axi3_slave against a byte-level memory model
module tb_axi3_slave;
    import axi3_pkg::*;

    localparam int NB  = AXI_DATA_W / 8;
    localparam int MEM = AXI_MEM_BYTES;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_if bus();
    axi3_slave dut (.aclk(aclk), .aresetn(aresetn), .axi(bus));

    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

    rbeat_t     rq[$];
    bexp_t      bq[$];
    logic [7:0] ref_mem [MEM];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake never completed", name);
    endtask

    function automatic logic illegal(logic [1:0] burst, int len, int size);
        return burst == 2'b11 || (burst == WRAP && len != 1 && len != 3 && len != 7 && len != 15) ||
               (1 << size) > NB;
    endfunction

    // Beat i address from the burst rules, using plain arithmetic on byte addresses
    function automatic logic [31:0] beat_addr(logic [31:0] addr, int len, int size, logic [1:0] burst, int i);
        longint step = longint'(1) << size;
        longint wb   = (len + 1) * step;
        longint a    = longint'(addr);
        longint al   = a / step * step;
        longint base = a / wb * wb;
        if (i == 0 || burst == FIXED) return addr;
        if (burst == WRAP) return 32'(base + (al - base + i * step) % wb);
        return 32'(al + i * step);
    endfunction

    function automatic logic [31:0] ref_word(logic [31:0] a);
        int w = int'(a) / NB * NB;
        return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
    endfunction

    task automatic outputs_zero(input string name);
        chk(name, 64'({bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.bid, bus.arready,
                       bus.rvalid, bus.rlast, bus.rresp, bus.rid}) | 64'(bus.rdata), 64'd0);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                            input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                            input bit rnd, input int bad_last);
        logic [31:0] dq[$];
        logic [3:0]  sq[$];
        logic        any_bad = 1'b0;
        int          n;
        for (int i = 0; i <= len; i++) begin
            logic [31:0] a = beat_addr(addr, len, size, burst, i);
            logic        bad = illegal(burst, len, size) || a >= 32'(MEM);
            dq.push_back(rnd ? $urandom : base * 32'(i + 1));
            sq.push_back(rnd ? 4'($urandom) : strb);
            any_bad |= bad;
            if (!bad)
                for (int k = 0; k < NB; k++)
                    if (sq[i][k]) ref_mem[int'(a) / NB * NB + k] = dq[i][8*k +: 8];
        end
        bq.push_back('{id, (any_bad || bad_last >= 0) ? SLVERR : OKAY});
        @(posedge aclk); #1;
        bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr; bus.awlen = 4'(len);
        bus.awsize = 3'(size); bus.awburst = burst;
        bus.awlock = 2'($urandom); bus.awcache = 4'($urandom); bus.awprot = 3'($urandom);
        n = 0;
        while (!bus.awready && n < 50) begin @(posedge aclk); #1; n++; end
        if (!bus.awready) timeout("aw");
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.wvalid = 1'b0;
            repeat ($urandom_range(0, 1)) begin @(posedge aclk); #1; end
            bus.wvalid = 1'b1; bus.wdata = dq[i]; bus.wstrb = sq[i]; bus.wid = 4'($urandom);
            bus.wlast = (i == len) ^ (i == bad_last);
            n = 0;
            while (!bus.wready && n < 50) begin @(posedge aclk); #1; n++; end
            if (!bus.wready) timeout("w");
            @(posedge aclk); #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
        bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 50) begin @(posedge aclk); #1; n++; end
        if (!bus.bvalid) timeout("b");
        @(posedge aclk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                           input logic [1:0] burst, input int hold);
        int got, n;
        for (int i = 0; i <= len; i++) begin
            logic [31:0] a = beat_addr(addr, len, size, burst, i);
            logic        bad = illegal(burst, len, size) || a >= 32'(MEM);
            rq.push_back('{id, bad ? 32'd0 : ref_word(a), bad ? SLVERR : OKAY, i == len});
        end
        @(posedge aclk); #1;
        bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr; bus.arlen = 4'(len);
        bus.arsize = 3'(size); bus.arburst = burst;
        bus.arlock = 2'($urandom); bus.arcache = 4'($urandom); bus.arprot = 3'($urandom);
        n = 0;
        while (!bus.arready && n < 50) begin @(posedge aclk); #1; n++; end
        if (!bus.arready) timeout("ar");
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        got = 0;
        n = 0;
        while (got <= len && n < 300) begin
            bus.rready = n >= hold && $urandom_range(0, 3) != 0;
            if (bus.rvalid && bus.rready) got++;
            @(posedge aclk); #1;
            n++;
        end
        bus.rready = 1'b0;
        if (got <= len) timeout("r");
    endtask

    // Monitor: pops the scoreboard on every B/R handshake and watches R stability under stall
    always @(negedge aclk) begin : mon
        rbeat_t      re;
        bexp_t       be;
        logic        hold_v;
        logic [34:0] hold_s;
        if (!aresetn) hold_v = 1'b0;
        else begin
            if (bus.bvalid && bus.bready) begin
                if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
                else begin
                    be = bq.pop_front();
                    chk("bid", 64'(bus.bid), 64'(be.id));
                    chk("bresp", 64'(bus.bresp), 64'(be.resp));
                end
            end
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
                else begin
                    re = rq.pop_front();
                    chk("rid", 64'(bus.rid), 64'(re.id));
                    chk("rdata", 64'(bus.rdata), 64'(re.data));
                    chk("rresp", 64'(bus.rresp), 64'(re.resp));
                    chk("rlast", 64'(bus.rlast), 64'(re.last));
                end
            end
            if (hold_v && bus.rvalid) chk("r_stable", 64'({bus.rdata, bus.rresp, bus.rlast}), 64'(hold_s));
            hold_v = bus.rvalid && !bus.rready;
            hold_s = {bus.rdata, bus.rresp, bus.rlast};
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0]  bt;
        logic [31:0] ad;
        int          sz, ln, k;
        for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;
        {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, bus.wlast} = '0;
        {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awprot} = '0;
        {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot} = '0;
        {bus.wid, bus.wdata, bus.wstrb} = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        outputs_zero("reset_outputs");
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("awready_after_reset", 64'(bus.awready), 64'd1);
        chk("arready_after_reset", 64'(bus.arready), 64'd1);

        for (int b = 0; b < 4; b++) do_write(4'd0, 32'(b * 64), 15, 2, INCR, 32'd0, 4'hF, 1'b0, -1);

        do_write(4'd3, 32'h10, 3, 2, INCR, 32'h11111111, 4'hF, 1'b0, -1);
        do_read(4'd5, 32'h10, 3, 2, INCR, 0);
        do_write(4'd1, 32'h00, 0, 2, INCR, 32'hAABBCCDD, 4'b0101, 1'b0, -1);
        do_read(4'd2, 32'h00, 0, 2, INCR, 0);
        chk("strobe_model", 64'(ref_word(32'h0)), 64'h00BB00DD);
        do_read(4'd6, 32'h18, 3, 2, WRAP, 0);
        do_write(4'd7, 32'h20, 2, 2, FIXED, 32'h0A0A0A0A, 4'hF, 1'b0, -1);
        do_read(4'd8, 32'h20, 0, 2, INCR, 0);
        do_write(4'd9, 32'(MEM), 0, 2, INCR, 32'hDEADBEEF, 4'hF, 1'b0, -1);
        do_read(4'd4, 32'h00, 1, 2, INCR, 0);
        do_read(4'hA, 32'h40, 3, 2, 2'b11, 0);
        do_read(4'hB, 32'h10, 3, 2, INCR, 3);
        do_write(4'hC, 32'h30, 3, 2, INCR, 32'h01020304, 4'hF, 1'b0, 1);
        do_write(4'hD, 32'h34, 1, 2, INCR, 32'h05060708, 4'hF, 1'b0, 1);

        for (int t = 0; t < 60; t++) begin
            k  = $urandom_range(0, 9);
            bt = k < 1 ? 2'b11 : k < 4 ? FIXED : k < 7 ? INCR : WRAP;
            sz = $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2);
            ln = bt != WRAP ? $urandom_range(0, 15) :
                 $urandom_range(0, 5) == 0 ? 2 : (2 << $urandom_range(0, 3)) - 1;
            ad = $urandom_range(0, 9) == 0 ? 32'(MEM + $urandom_range(0, 1000)) :
                 32'($urandom_range(0, 256 - ((ln + 1) << sz)));
            if ($urandom_range(0, 1) == 0)
                do_write(4'($urandom), ad, ln, sz, bt, 32'd0, 4'hF, 1'b1,
                         $urandom_range(0, 9) == 0 ? $urandom_range(0, ln) : -1);
            else
                do_read(4'($urandom), ad, ln, sz, bt, $urandom_range(0, 2));
        end

        @(posedge aclk); #1;
        bus.awvalid = 1'b1; bus.awid = 4'h5; bus.awaddr = 32'h80; bus.awlen = 4'd3;
        bus.awsize = 3'd2; bus.awburst = INCR;
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wlast = 1'b0;
        @(posedge aclk); #1;
        bus.wvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        outputs_zero("midburst_reset_outputs");
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("idle_after_abort", 64'({bus.awready, bus.wready, bus.arready}), 64'b101);
        bus.bready = 1'b1;
        repeat (4) @(posedge aclk);
        #1;
        chk("no_b_after_abort", 64'(bus.bvalid), 64'd0);
        bus.bready = 1'b0;

        chk("b_queue_drained", 64'(bq.size()), 64'd0);
        chk("r_queue_drained", 64'(rq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi3_slave.md
# axi3_slave

AXI3 slave endpoint backed by an internal byte-addressable memory; it is the design under test in the AXI verification environment, driven by the bench through the `axi_if` interface. It accepts one write burst and one read burst at a time, with the two directions independent. It supports the FIXED, INCR and WRAP burst types, byte strobes, and OKAY/SLVERR responses.

## Interface
- ID_W, 4, width of all ID fields
- ADDR_W, 32, address width
- DATA_W, 32, data bus width (power of two, ≥ 8)
- MEM_BYTES, 4096, memory size in bytes; valid addresses are 0..MEM_BYTES-1
- aclk  in  1  clock; all logic is on the rising edge
- aresetn  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  ID_W/ADDR_W/4/3/2/2/4/3  write address
- awvalid in 1; awready out 1
- wid/wdata/wstrb/wlast/wvalid  in  ID_W/DATA_W/DATA_W/8/1/1  write data; wready out 1
- bid out ID_W; bresp out 2; bvalid out 1; bready in 1
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  same widths as AW; arvalid in 1; arready out 1
- rid out ID_W; rdata out DATA_W; rresp out 2; rlast out 1; rvalid out 1; rready in 1

## Operation
- Handshake: a transfer occurs on a rising edge with valid && ready both high.
- awlock, awcache, awprot, arlock, arcache and arprot are ignored.
- wid is ignored; bid is the captured awid.
- Write FSM has three states:
  - W_IDLE: awready=1. On an AW handshake, capture id, addr, len, size and burst, then go to W_DATA.
  - W_DATA: wready=1. Each beat writes the bytes whose wstrb bit is set at the current address, aligned down to DATA_W/8. The address then advances. After beat awlen+1, go to W_RESP.
  - W_RESP: bvalid=1. Hold bid and bresp until bready, then go to W_IDLE.
- Read FSM has two states:
  - R_IDLE: arready=1. On an AR handshake, capture the AR fields, load beat 0 into rdata, and go to R_DATA.
  - R_DATA: rvalid=1. rlast=1 on beat arlen. On each R handshake, load the next beat; after the last beat go to R_IDLE.
- Address sequence:
  - FIXED: the address stays constant.
  - INCR: address = aligned(addr, size) + 2^size.
  - WRAP: as INCR, but wraps within a (len+1)·2^size-byte aligned window.
- Error conditions produce SLVERR; the burst still runs to its full length:
  - burst = 2'b11
  - WRAP with len not in {1,3,7,15}
  - 2^size > DATA_W/8
  - any beat address ≥ MEM_BYTES
- Errored write beats are discarded.
- Errored read beats return rdata=0 with rresp=SLVERR. Other read beats return rresp=OKAY.
- bresp is SLVERR if any beat errored, or if the wlast value mismatches its expected position (high early, or low on the final beat). Otherwise bresp is OKAY.
- Memory contents are not cleared by reset.

## Timing
- Reset values: all outputs are 0, including awready, wready, arready, bvalid, rvalid, rlast, bresp, rresp, bid, rid and rdata.
- The FSMs enter the IDLE states under reset. awready and arready rise on the first rising edge after aresetn deasserts.
- All outputs are registered.
- AW handshake → wready high on the next cycle; awready is low from then until B completes.
- The last W handshake → bvalid on the next cycle.
- AR handshake → rvalid with beat 0 on the next cycle.
- Back-to-back R beats at one per cycle while rready is high. rdata, rresp and rlast are stable while rvalid && !rready.
- Read/write collision on the same address: reads see writes committed on earlier edges. A same-edge write is not visible.
- Reset asserted mid-burst aborts the burst immediately. No response is issued afterward.

## Structure
- Package axi3_pkg holds:
  - burst enum: FIXED=2'b00, INCR=2'b01, WRAP=2'b10
  - resp constants: OKAY=2'b00, SLVERR=2'b10
  - width defaults
- Sub-module axi3_addr_gen computes the next address from addr, size, len and burst. It is instantiated once per direction.

## Test plan
- Reset: during reset all outputs are 0; one cycle after release awready=arready=1.
- INCR write: awaddr=0x10, len=3, size=2, data 0x11111111..0x44444444, wstrb=F → bresp=OKAY. A read of the same burst returns the 4 words with rlast on beat 3.
- Strobes: write 0xAABBCCDD to 0x0 with wstrb=4'b0101 over prior contents 0 → read returns 0x00BB00DD.
- WRAP: read araddr=0x18, len=3, size=2 → addresses 0x18, 0x1C, 0x10, 0x14.
- FIXED: write len=2 to 0x20 → only the last beat's data remains at 0x20.
- Errors:
  - awaddr=MEM_BYTES → bresp=SLVERR and no memory change
  - arburst=2'b11 → every beat has rresp=SLVERR and rdata=0
  - rready held low for 3 cycles → rdata stable
